// File: rtl/ha_sched_pkg.sv
// Shared types and constants for the bit-serial add scheduler.
package ha_sched_pkg;

  localparam int unsigned NUM_REQ = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/ha_full_cell.sv
// One-bit full adder assembled from two half-adder cells and an OR gate.
module ha_half_cell (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  // Sum and carry of two bits.
  assign s = a ^ b;
  assign c = a & b;

endmodule

module ha_full_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic s0;
  logic c0;
  logic c1;

  ha_half_cell u_ha0 (
    .a (a),
    .b (b),
    .s (s0),
    .c (c0)
  );

  ha_half_cell u_ha1 (
    .a (s0),
    .b (cin),
    .s (s),
    .c (c1)
  );

  // At most one half adder can carry, so an OR merges them.
  assign cout = c0 | c1;

endmodule

// File: rtl/ha_serial_sched.sv
// Round-robin arbiter feeding a shared bit-serial adder, LSB first over WIDTH cycles.
module ha_serial_sched
  import ha_sched_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [WIDTH-1:0]     a0,
  input  logic [WIDTH-1:0]     b0,
  input  logic [WIDTH-1:0]     a1,
  input  logic [WIDTH-1:0]     b1,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [WIDTH:0]       rsp_sum,
  output logic                 busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_t             state_q, state_d;
  req_id_t            last_q, last_d;
  req_id_t            id_q, id_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  req_id_t            rsp_id_q, rsp_id_d;
  logic [WIDTH:0]     rsp_sum_q, rsp_sum_d;
  logic               busy_q, busy_d;

  req_id_t            grant;
  logic               cell_s;
  logic               cell_c;

  ha_full_cell u_cell (
    .a    (opa_q[0]),
    .b    (opb_q[0]),
    .cin  (carry_q),
    .s    (cell_s),
    .cout (cell_c)
  );

  // Tie goes to the requester not served last; otherwise the lone valid one wins.
  assign grant = (req_valid == 2'b11) ? ~last_q : req_valid[1];

  // State register and datapath flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      id_q        <= 1'b0;
      opa_q       <= '0;
      opb_q       <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, arbitration and serial datapath sequencing.
  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    id_d      = id_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cnt_d     = cnt_q;
    rsp_id_d  = rsp_id_q;
    rsp_sum_d = rsp_sum_q;
    req_ready = '0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready[grant] = 1'b1;
          opa_d   = grant ? a1 : a0;
          opb_d   = grant ? b1 : b0;
          id_d    = grant;
          last_d  = grant;
          sum_d   = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = cell_c;
        sum_d   = {cell_s, sum_q[WIDTH-1:1]};
        opa_d   = opa_q >> 1;
        opb_d   = opb_q >> 1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          rsp_sum_d = {cell_c, cell_s, sum_q[WIDTH-1:1]};
          rsp_id_d  = id_q;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    rsp_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ha_serial_sched.sv
// Scoreboard bench for ha_serial_sched: directed scenarios followed by random traffic.
module tb_ha_serial_sched;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [W-1:0]   a0, b0, a1, b1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic           rsp_id;
  logic [W:0]     rsp_sum;
  logic           busy;

  typedef struct {
    logic       id;
    logic [W:0] sum;
  } exp_t;

  exp_t exp_q[$];

  int n_checks = 0;
  int n_errors = 0;

  ha_serial_sched #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .a0        (a0),
    .b0        (b0),
    .a1        (a1),
    .b1        (b1),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the scheduler is free, computing for W cycles, or holding a result.
  int         m_run_left;
  logic       m_done;
  logic       m_last;
  logic       m_idle;
  logic       m_g;
  logic [1:0] m_rdy;
  exp_t       m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_run_left = 0;
      m_done     = 1'b0;
      m_last     = 1'b1;
      exp_q.delete();
    end else begin
      m_idle = !m_done && (m_run_left == 0);
      m_rdy  = 2'b00;
      m_g    = 1'b0;
      if (m_idle && (req_valid != 2'b00)) begin
        m_g = (req_valid == 2'b11) ? !m_last : req_valid[1];
        m_rdy[m_g] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(m_rdy));
      check("busy", 32'(busy), 32'(!m_idle));
      check("rsp_valid", 32'(rsp_valid), 32'(m_done));
      if (m_rdy != 2'b00) begin
        m_e.id  = m_g;
        m_e.sum = m_g ? ({1'b0, a1} + {1'b0, b1}) : ({1'b0, a0} + {1'b0, b0});
        exp_q.push_back(m_e);
        m_last     = m_g;
        m_run_left = W;
      end else if (m_run_left > 0) begin
        m_run_left--;
        if (m_run_left == 0) m_done = 1'b1;
      end else if (m_done && rsp_ready) begin
        m_done = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each response handshake and checks hold stability.
  logic       hold;
  logic       prev_id;
  logic [W:0] prev_sum;
  exp_t       got;

  always @(negedge clk) begin
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_sum", 32'(rsp_sum), 32'(prev_sum));
        check("hold_id", 32'(rsp_id), 32'(prev_id));
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_rsp: got id %0d sum 0x%0h, expected none", rsp_id, rsp_sum);
        end else begin
          got = exp_q.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(got.id));
          check("rsp_sum", 32'(rsp_sum), 32'(got.sum));
        end
      end
      hold     = rsp_valid && !rsp_ready;
      prev_id  = rsp_id;
      prev_sum = rsp_sum;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [1:0] v, input logic [W-1:0] x0, input logic [W-1:0] y0,
                       input logic [W-1:0] x1, input logic [W-1:0] y1);
    req_valid = v;
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    tick();
    req_valid = 2'b00;
  endtask

  int grants;
  int guard;

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b1;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    tick();

    // Single requests, including a full carry ripple.
    pulse(2'b01, 8'h5A, 8'h3C, 8'h00, 8'h00);
    repeat (W + 4) tick();
    pulse(2'b10, 8'h00, 8'h00, 8'hFF, 8'h01);
    repeat (W + 4) tick();

    // Both requesters held across three grants.
    req_valid = 2'b11;
    a0 = 8'h11; b0 = 8'h22; a1 = 8'h33; b1 = 8'h44;
    grants = 0; guard = 0;
    while (grants < 3 && guard < 200) begin
      #1;
      if (req_ready != 2'b00) grants++;
      @(posedge clk);
      #1;
      a0 = 8'($urandom); a1 = 8'($urandom);
      guard++;
    end
    req_valid = 2'b00;
    check("tie_grants", 32'(grants), 32'd3);
    repeat (W + 4) tick();

    // Backpressure with a competing request pending.
    rsp_ready = 1'b0;
    pulse(2'b01, 8'h12, 8'h34, 8'h00, 8'h00);
    req_valid = 2'b11;
    guard = 0;
    while (!rsp_valid && guard < 50) begin
      tick();
      guard++;
    end
    check("bp_valid_seen", 32'(rsp_valid), 32'd1);
    repeat (5) tick();
    rsp_ready = 1'b1;
    req_valid = 2'b00;
    repeat (W + 4) tick();

    // Reset during the fourth RUN cycle.
    pulse(2'b01, 8'hAB, 8'hCD, 8'h00, 8'h00);
    repeat (3) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_sum", 32'(rsp_sum), 32'd0);
    check("abort_rsp_id", 32'(rsp_id), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    pulse(2'b11, 8'h01, 8'h01, 8'h7F, 8'h80);
    repeat (W + 4) tick();

    // Boundary operands.
    pulse(2'b01, 8'h00, 8'h00, 8'h00, 8'h00);
    repeat (W + 4) tick();
    pulse(2'b10, 8'h00, 8'h00, 8'hFF, 8'hFF);
    repeat (W + 4) tick();

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (2 * W + 6) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
